// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the two-requester ALU arbiter.
//   - FSM state enum (IDLE, EXEC, RESP)
//   - op-code constants (OP_NOT = ~a, OP_ADD = a+b)
//   - requester count and grant-counter width
//   - small helpers: one-hot grant decode, saturating counter increment
package alu_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int STATS_W = 16;

  localparam logic OP_NOT = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester index -> one-hot bit in a NUM_REQ-wide vector.
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshake bundle between the two
// requesters and the arbiter.
//   req_valid/req_ready/req_op [1:0], req_a0/req_b0/req_a1/req_b1 [n-1:0]
//   rsp_valid/rsp_ready [1:0], rsp_data [n-1:0], busy
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if #(parameter int n = 8);

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_op;
  logic [n-1:0] req_a0;
  logic [n-1:0] req_b0;
  logic [n-1:0] req_a1;
  logic [n-1:0] req_b1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [n-1:0] rsp_data;
  logic         busy;

  modport master (
    output req_valid, req_op, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/alu_core.sv
// alu_core: registered ALU stage.
//   clk, rst_n (sync, active-low) ; op (OP_ADD: a+b mod 2^n, OP_NOT: ~a)
//   a, b [n-1:0] operands ; en: capture enable ; q [n-1:0]: registered result
// q resets to 0 and only changes when en is high.
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         en,
  output logic [n-1:0] q
);

  // Sum is kept at n bits so the carry falls off naturally.
  function automatic logic [n-1:0] alu_fn(input logic f_op, input logic [n-1:0] f_a,
                                          input logic [n-1:0] f_b);
    logic [n-1:0] res;
    if (f_op == OP_ADD) begin
      res = f_a + f_b;
    end else begin
      res = ~f_a;
    end
    return res;
  endfunction

  logic [n-1:0] q_r;

  // Result register: loads only in the execute cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= {n{1'b0}};
    end else if (en) begin
      q_r <= alu_fn(op, a, b);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU between two
// requesters, one operation in flight at a time (IDLE -> EXEC -> RESP).
//   clk, rst_n (sync, active-low)
//   bus (alu_arbiter_if.slave): req_valid/req_ready/req_op, operands,
//     rsp_valid/rsp_ready/rsp_data, busy
// Optional build macro ALU_ARB_STATS_EN adds gnt_cnt0/gnt_cnt1 [15:0]:
// saturating per-requester grant counters.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int n = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_arbiter_if.slave       bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] gnt_cnt0,
  output logic [STATS_W-1:0] gnt_cnt1
`endif
);

  state_t       state_r;
  state_t       state_s;
  logic         pri_r;
  logic         gnt_r;
  logic         op_r;
  logic [n-1:0] a_r;
  logic [n-1:0] b_r;
  logic [1:0]   rsp_valid_r;
  logic         busy_r;

  logic         gnt_s;
  logic         grant_s;
  logic [1:0]   req_ready_s;
  logic         op_s;
  logic [n-1:0] a_s;
  logic [n-1:0] b_s;
  logic [n-1:0] q_s;

  // Arbiter: pri only breaks ties; a lone requester always wins.
  // Grant is suppressed while reset is held so req_ready reads 0.
  always_comb begin
    gnt_s       = 1'b0;
    grant_s     = 1'b0;
    req_ready_s = 2'b00;
    if (bus.req_valid == 2'b11) begin
      gnt_s = pri_r;
    end else begin
      gnt_s = bus.req_valid[1];
    end
    if ((state_r == IDLE) && (bus.req_valid != 2'b00) && rst_n) begin
      grant_s     = 1'b1;
      req_ready_s = req_onehot(gnt_s);
    end else begin
      grant_s     = 1'b0;
      req_ready_s = 2'b00;
    end
  end

  // Operand select for the winning requester.
  always_comb begin
    op_s = bus.req_op[0];
    a_s  = bus.req_a0;
    b_s  = bus.req_b0;
    if (gnt_s) begin
      op_s = bus.req_op[1];
      a_s  = bus.req_a1;
      b_s  = bus.req_b1;
    end else begin
      op_s = bus.req_op[0];
      a_s  = bus.req_a0;
      b_s  = bus.req_b0;
    end
  end

  // Next-state logic; only the granted requester's rsp_ready matters.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        state_s = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[gnt_r]) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, priority pointer, latched request and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pri_r       <= 1'b0;
      gnt_r       <= 1'b0;
      op_r        <= OP_NOT;
      a_r         <= {n{1'b0}};
      b_r         <= {n{1'b0}};
      rsp_valid_r <= 2'b00;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      // gnt_r is already stable by the time RESP can be entered.
      rsp_valid_r <= (state_s == RESP) ? req_onehot(gnt_r) : 2'b00;
      busy_r      <= (state_s != IDLE);
      if (grant_s) begin
        gnt_r <= gnt_s;
        pri_r <= ~gnt_s;
        op_r  <= op_s;
        a_r   <= a_s;
        b_r   <= b_s;
      end else begin
        gnt_r <= gnt_r;
        pri_r <= pri_r;
        op_r  <= op_r;
        a_r   <= a_r;
        b_r   <= b_r;
      end
    end
  end

  alu_core #(.n(n)) u_alu_core (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (op_r),
    .a     (a_r),
    .b     (b_r),
    .en    (state_r == EXEC),
    .q     (q_s)
  );

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = q_s;
  assign bus.busy      = busy_r;

`ifdef ALU_ARB_STATS_EN
  logic [STATS_W-1:0] gnt_cnt0_r;
  logic [STATS_W-1:0] gnt_cnt1_r;

  // Grant counters, bumped in the grant cycle and sticky at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_cnt0_r <= 16'd0;
      gnt_cnt1_r <= 16'd0;
    end else if (grant_s) begin
      if (gnt_s) begin
        gnt_cnt0_r <= gnt_cnt0_r;
        gnt_cnt1_r <= sat_inc(gnt_cnt1_r);
      end else begin
        gnt_cnt0_r <= sat_inc(gnt_cnt0_r);
        gnt_cnt1_r <= gnt_cnt1_r;
      end
    end else begin
      gnt_cnt0_r <= gnt_cnt0_r;
      gnt_cnt1_r <= gnt_cnt1_r;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_r;
  assign gnt_cnt1 = gnt_cnt1_r;
`endif

endmodule
